// File: rtl/prga.sv
// ARC4 keystream generator and decryptor: continues the i/j swap walk over S memory
// and XORs a length-prefixed ciphertext into a length-prefixed plaintext.
module prga (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    typedef enum logic [3:0] {
        IDLE, LEN_A, LEN_D, RD_I, RD_J, WR_I, WR_J, RD_PAD, XOR
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] i, j, k, len, si, sj, ct_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i       <= '0;
            j       <= '0;
            k       <= '0;
            len     <= '0;
            si      <= '0;
            sj      <= '0;
            ct_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
                LEN_D: begin
                    len <= ct_rddata;
                    i   <= 8'd1;
                    k   <= 8'd1;
                end
                RD_J: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                WR_I: sj      <= s_rddata;
                WR_J: ct_byte <= ct_rddata;
                XOR: begin
                    if (k != len) begin
                        k <= k + 8'd1;
                        i <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = IDLE;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        case (state)
            IDLE: begin
                rdy       = 1'b1;
                state_nxt = en ? LEN_A : IDLE;
            end
            LEN_A: state_nxt = LEN_D;
            LEN_D: begin
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_nxt = (ct_rddata == 8'd0) ? IDLE : RD_I;
            end
            RD_I: begin
                s_addr    = i;
                state_nxt = RD_J;
            end
            // The new j is needed as an address this cycle, before it is registered.
            RD_J: begin
                s_addr    = j + s_rddata;
                state_nxt = WR_I;
            end
            WR_I: begin
                s_addr    = i;
                s_wrdata  = s_rddata;
                s_wren    = 1'b1;
                ct_addr   = k;
                state_nxt = WR_J;
            end
            WR_J: begin
                s_addr    = j;
                s_wrdata  = si;
                s_wren    = 1'b1;
                ct_addr   = k;
                state_nxt = RD_PAD;
            end
            RD_PAD: begin
                s_addr    = si + sj;
                state_nxt = XOR;
            end
            XOR: begin
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ct_byte;
                pt_wren   = 1'b1;
                state_nxt = (k == len) ? IDLE : RD_I;
            end
            default: begin
                rdy       = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Bench for prga: memory models, table-driven runs, and a scoreboard of expected
// plaintext writes checked as the DUT issues them.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n, en, rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic       s_wren, pt_wren;

    prga dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] smem[256], ctmem[256], load_s[256], load_ct[256], model_s[256];
    logic       load;

    always @(posedge clk) begin
        if (load) begin
            smem  <= load_s;
            ctmem <= load_ct;
        end else if (s_wren) begin
            smem[s_addr] <= s_wrdata;
        end
        s_rddata  <= smem[s_addr];
        ct_rddata <= ctmem[ct_addr];
    end

    typedef struct {
        int              skind;   // 0 identity S, 1 key-schedule of "Key", 2 keep current S
        logic [10:0][7:0] ct;
        logic [10:0][7:0] pt;
        int              busy;
    } vec_t;

    vec_t        vecs[3];
    int          checks, errors, pt_wr_cnt, s_wr_cnt;
    logic [15:0] sb_q[$];
    bit          sb_on;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (s_wren || pt_wren) begin
                    checks++;
                    if ((s_wren && pt_wren) || (s_wren && $isunknown(s_addr)) ||
                        (pt_wren && $isunknown(pt_addr))) begin
                        errors++;
                        $display("FAIL protocol actual s_wren=%b pt_wren=%b s_addr=%h pt_addr=%h required one clean write",
                                 s_wren, pt_wren, s_addr, pt_addr);
                    end
                end
                if (s_wren) s_wr_cnt++;
                if (pt_wren) begin
                    pt_wr_cnt++;
                    if (sb_on) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL pt_write actual=%h:%h required=none", pt_addr, pt_wrdata);
                        end else begin
                            e = sb_q.pop_front();
                            if ({pt_addr, pt_wrdata} !== e) begin
                                errors++;
                                $display("FAIL pt_write actual=%h:%h required=%h:%h",
                                         pt_addr, pt_wrdata, e[15:8], e[7:0]);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic ksa_key();
        logic [7:0] kb[3];
        logic [7:0] kj, t;
        kb[0] = 8'h4B; kb[1] = 8'h65; kb[2] = 8'h79;
        for (int unsigned x = 0; x < 256; x++) load_s[x] = x[7:0];
        kj = '0;
        for (int unsigned x = 0; x < 256; x++) begin
            kj = kj + load_s[x] + kb[x % 3];
            t = load_s[x]; load_s[x] = load_s[kj]; load_s[kj] = t;
        end
    endtask

    task automatic load_mems();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_s = load_s;
    endtask

    // Reference ARC4 on the bench's own copy of S; pushes every expected pt write.
    task automatic model_push();
        logic [7:0] mi, mj, t, n;
        n = load_ct[0];
        sb_q.push_back({8'h00, n});
        mi = '0; mj = '0;
        for (int unsigned m = 1; m <= n; m++) begin
            mi = mi + 8'd1;
            mj = mj + model_s[mi];
            t = model_s[mi]; model_s[mi] = model_s[mj]; model_s[mj] = t;
            t = model_s[mi] + model_s[mj];
            sb_q.push_back({m[7:0], model_s[t] ^ load_ct[m]});
        end
    endtask

    task automatic run_and_time(output int low);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        low = 0;
        while (rdy !== 1'b1 && low < 3000) begin
            low++;
            @(negedge clk);
        end
    endtask

    task automatic run_row(input int v);
        int low, pw0, sw0, n, bad;
        if (vecs[v].skind == 0)      for (int unsigned x = 0; x < 256; x++) load_s[x] = x[7:0];
        else if (vecs[v].skind == 1) ksa_key();
        else                         load_s = smem;
        for (int unsigned m = 0; m < 256; m++) load_ct[m] = (m <= 10) ? vecs[v].ct[m] : 8'h00;
        load_mems();
        n = int'(vecs[v].ct[0]);
        for (int m = 0; m <= n; m++) sb_q.push_back({m[7:0], vecs[v].pt[m]});
        pw0 = pt_wr_cnt; sw0 = s_wr_cnt;
        run_and_time(low);
        check($sformatf("row%0d_busy", v), low, vecs[v].busy);
        check($sformatf("row%0d_queue_left", v), sb_q.size(), 0);
        check($sformatf("row%0d_pt_writes", v), pt_wr_cnt - pw0, n + 1);
        if (n == 0) check("zero_len_s_wren", s_wr_cnt - sw0, 0);
        if (vecs[v].skind == 0) begin
            check("ident_s2", smem[2], 8'h03);
            check("ident_s3", smem[3], 8'h02);
            bad = 0;
            for (int unsigned x = 0; x < 256; x++)
                if (x != 2 && x != 3 && smem[x] !== x[7:0]) bad++;
            check("ident_s_others", bad, 0);
        end
        sb_q.delete();
    endtask

    initial begin
        int low, hi, pw0;
        checks = 0; errors = 0; pt_wr_cnt = 0; s_wr_cnt = 0;
        sb_on = 1'b1; en = 1'b0; load = 1'b0;
        for (int unsigned x = 0; x < 256; x++) begin
            load_s[x] = '0; load_ct[x] = '0;
        end

        vecs[0].skind = 1;
        vecs[0].ct = {8'h00, 8'hD3, 8'h0A, 8'hAF, 8'h40, 8'hD9, 8'hE8, 8'h16, 8'hF3, 8'hBB, 8'h09};
        vecs[0].pt = {8'h00, 8'h74, 8'h78, 8'h65, 8'h74, 8'h6E, 8'h69, 8'h61, 8'h6C, 8'h50, 8'h09};
        vecs[0].busy = 56;
        vecs[1].skind = 0;
        vecs[1].ct = 88'h000002;
        vecs[1].pt = 88'h050202;
        vecs[1].busy = 14;
        vecs[2].skind = 2;
        vecs[2].ct = '0;
        vecs[2].pt = '0;
        vecs[2].busy = 2;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_rdy", rdy, 1);
        check("rst_s_wren", s_wren, 0);
        check("rst_pt_wren", pt_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_ct_addr", ct_addr, 0);
        check("rst_pt_addr", pt_addr, 0);
        check("rst_s_wrdata", s_wrdata, 0);
        check("rst_pt_wrdata", pt_wrdata, 0);
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) run_row(v);

        // Longest message: k must stop at 255 without wrapping.
        ksa_key();
        load_ct[0] = 8'hFF;
        for (int unsigned m = 1; m < 256; m++) load_ct[m] = 8'($urandom);
        load_mems();
        model_push();
        pw0 = pt_wr_cnt;
        run_and_time(low);
        check("len255_busy", low, 1532);
        check("len255_queue_left", sb_q.size(), 0);
        check("len255_pt_writes", pt_wr_cnt - pw0, 256);
        sb_q.delete();

        // en held high: back-to-back runs separated by one idle cycle.
        for (int unsigned x = 0; x < 256; x++) begin
            load_s[x] = x[7:0]; load_ct[x] = 8'h00;
        end
        load_ct[0] = 8'h01; load_ct[1] = 8'h5A;
        load_mems();
        model_push();
        model_push();
        pw0 = pt_wr_cnt;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        low = 0;
        while (rdy !== 1'b1 && low < 100) begin low++; @(negedge clk); end
        check("hs_low1", low, 8);
        hi = 0;
        while (rdy === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
        check("hs_high", hi, 1);
        low = 0;
        while (rdy !== 1'b1 && low < 100) begin
            low++;
            if (low == 3) en = 1'b0;
            if (low == 4) en = 1'b1;
            if (low == 5) en = 1'b0;
            @(negedge clk);
        end
        check("hs_low2", low, 8);
        repeat (5) @(negedge clk);
        check("hs_stays_idle", rdy, 1);
        check("hs_pt_writes", pt_wr_cnt - pw0, 4);
        check("hs_queue_left", sb_q.size(), 0);
        sb_q.delete();

        // Asynchronous reset during WR_I of byte 3.
        sb_on = 1'b0;
        ksa_key();
        for (int unsigned m = 0; m < 256; m++) load_ct[m] = (m <= 10) ? vecs[0].ct[m] : 8'h00;
        load_mems();
        pw0 = pt_wr_cnt;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (16) @(negedge clk);
        check("mid_wr_i_s_wren", s_wren, 1);
        check("mid_wr_i_s_addr", s_addr, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_s_wren", s_wren, 0);
        check("mid_rst_pt_wren", pt_wren, 0);
        check("mid_rst_rdy", rdy, 1);
        check("mid_rst_pt_writes", pt_wr_cnt - pw0, 3);
        @(negedge clk);
        rst_n = 1'b1;
        sb_on = 1'b1;
        run_row(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prga.md
Name: prga

Overview:
ARC4 pseudo-random generation and decryption engine. It is the consumer of the S-box that the key-scheduling block leaves in S memory.
- Reads S and continues the i/j swap walk.
- Reads a length-prefixed ciphertext from CT memory, XORs each byte with the keystream, and writes a length-prefixed plaintext to PT memory.
- Sits after key scheduling in the decrypt pipeline and uses the same en/rdy start handshake.

Parameters:
None. All widths are fixed at 8 bits (256-entry memories).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  start request, sampled only while rdy=1
rdy  output  1  1 = idle, ready to accept en
s_addr  output  8  S memory address
s_rddata  input  8  S memory read data, 1-cycle synchronous latency
s_wrdata  output  8  S memory write data
s_wren  output  1  S memory write enable
ct_addr  output  8  ciphertext memory address
ct_rddata  input  8  ciphertext read data, 1-cycle latency
pt_addr  output  8  plaintext memory address
pt_wrdata  output  8  plaintext write data
pt_wren  output  1  plaintext write enable

Behaviour:
- Reset is asynchronous and active-low on rst_n; everything runs on the single clock clk.
- Reset:
  - state=IDLE; i, j, k, len, si, sj and ct_byte are all 0.
  - Outputs (combinational from state and regs) are immediately rdy=1, all addresses 0, all wdata 0, s_wren=0, pt_wren=0.
- Memory model: an address presented in cycle N returns data in cycle N+1. Writes commit at the clock edge when wren=1.
- Handshake:
  - In IDLE, rdy=1; en=1 at a clock edge starts a run, and rdy=0 from the next cycle.
  - en is ignored while rdy=0.
  - If en is still high when IDLE is re-entered, a new run starts after exactly one rdy=1 cycle.
- States and per-state actions:
  - IDLE: i<=0, j<=0, k<=0. Go to LEN_A on en.
  - LEN_A: ct_addr=0 → LEN_D.
  - LEN_D: len<=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1; i<=1, k<=1. If ct_rddata==0 → IDLE, else → RD_I.
  - RD_I: s_addr=i → RD_J.
  - RD_J: si<=s_rddata; j<=j+s_rddata (mod 256); s_addr=j+s_rddata (combinational) → WR_I.
  - WR_I: sj<=s_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1; ct_addr=k → WR_J.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1; ct_byte<=ct_rddata; ct_addr=k → RD_PAD.
  - RD_PAD: s_addr=si+sj (mod 256) → XOR.
  - XOR: pt_addr=k, pt_wrdata=s_rddata^ct_byte, pt_wren=1. If k==len → IDLE; else k<=k+1, i<=i+1 → RD_I.
- Arithmetic: all sums are 8-bit, wrapping mod 256. i wraps 255→0 naturally.
- Latency: 6 cycles per byte, so rdy is low for exactly 2+6*len cycles (len=0 gives 2).
- i==j: the two swap writes hit the same address and the final value is si, which is correct ARC4 behaviour.
- A pad index equal to i or j reads post-swap data, as ARC4 requires.
- len=255: k reaches 255 and terminates on the k==len compare. k never wraps.
- S memory is left in its post-run state. A new run restarts i and j at 0 but does not restore S.
- rst_n low mid-run: asynchronous return to IDLE; s_wren and pt_wren drop immediately. Partially written memories are not repaired.
- Only one of s_wren and pt_wren is ever high in a given cycle. No state reads and writes S in the same cycle.
- Unreachable state encodings → IDLE, with all outputs as in IDLE.

Test Plan:
- Known-answer vector:
  - Stimulus: S preloaded with the key-schedule result of key 24'h4B6579 ("Key"); ct=[09,BB,F3,16,E8,D9,40,AF,0A,D3]; pulse en.
  - Required: pt=[09,50,6C,61,69,6E,74,65,78,74] ("Plaintext"); rdy low exactly 56 cycles.
- Identity S:
  - Stimulus: S[x]=x, ct=[02,00,00].
  - Required: pt=[02,02,05]; S[2]=03, S[3]=02, every other S entry unchanged.
- Zero length:
  - Stimulus: ct[0]=00.
  - Required: pt[0]=00 written once; rdy low exactly 2 cycles; s_wren never asserted; no other pt writes.
- Handshake:
  - Stimulus: en held high continuously with ct=[01,xx].
  - Required: rdy low 8 cycles, high exactly 1 cycle, then a second run begins. en pulses mid-run are ignored (pt write count unchanged).
- Reset mid-run:
  - Stimulus: drop rst_n asynchronously during WR_I of byte 3.
  - Required: s_wren=0 and pt_wren=0 in the same cycle, rdy=1; after release, a new en runs cleanly.
- Protocol checker (every run): assert s_wren and pt_wren are never both high; assert no address is X while its wren=1.
